// File: rtl/mprj_tie_pkg.sv
// Shared types and constants for the tie-high bank monitor.
package mprj_tie_pkg;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } tie_state_t;

  // Default number of lines examined per scan cycle.
  localparam int DEF_CHUNK = 32;

  // Number of scan cycles needed to cover the whole bank (rounded up).
  function automatic int calc_nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/mprj_tie_chunk_chk.sv
// Combinational checker for one chunk of tie-high lines: counts the low
// lines that are inside the valid mask and finds the lowest such line.
module mprj_tie_chunk_chk import mprj_tie_pkg::*; #(
  parameter int CHUNK = DEF_CHUNK,
  localparam int ZCW  = $clog2(CHUNK + 1),
  localparam int POSW = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] bits,
  input  logic [CHUNK-1:0] valid,
  output logic [ZCW-1:0]   zero_cnt,
  output logic [POSW-1:0]  low_pos,
  output logic             any_zero
);

  logic [CHUNK-1:0] zeros_s;

  // Popcount of masked zeros; walk high-to-low so the last hit is the lowest.
  always_comb begin
    zeros_s  = ~bits & valid;
    zero_cnt = '0;
    low_pos  = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      zero_cnt = zero_cnt + ZCW'(zeros_s[i]);
      low_pos  = zeros_s[i] ? POSW'(i) : low_pos;
    end
    any_zero = |zeros_s;
  end

endmodule

// File: rtl/mprj_tie_monitor.sv
// Tie-high bank monitor: scans hi_i one chunk per clock, counts low lines,
// records the lowest failing index and raises a sticky alarm.
// Build option: define MPRJ_TIE_MON_CONT_EN for continuous back-to-back
// scanning; otherwise each scan needs its own start_i.
module mprj_tie_monitor import mprj_tie_pkg::*; #(
  parameter int WIDTH = 463,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [WIDTH-1:0]           hi_i,
  input  logic                       start_i,
  input  logic                       clr_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       fault_o,
  output logic [$clog2(WIDTH+1)-1:0] fault_cnt_o,
  output logic [$clog2(WIDTH)-1:0]   first_idx_o
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int PADW   = NCHUNK * CHUNK;
  localparam int PTRW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CNTW   = $clog2(WIDTH + 1);
  localparam int IDXW   = $clog2(WIDTH);
  localparam int ZCW    = $clog2(CHUNK + 1);
  localparam int POSW   = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  tie_state_t        state_r;
  tie_state_t        state_nxt_s;
  logic [PTRW-1:0]   ptr_r;
  logic [PADW-1:0]   padded_s;
  logic [CHUNK-1:0]  chunk_s;
  logic [CHUNK-1:0]  valid_s;
  logic [ZCW-1:0]    zero_cnt_s;
  logic [POSW-1:0]   low_pos_s;
  logic              any_zero_s;
  logic [IDXW-1:0]   idx_cand_s;
  logic              last_chunk_s;
  logic              restart_s;
  logic              scanning_s;

  // Pad the bank to whole chunks with ones and select the current chunk.
  always_comb begin
    padded_s            = '1;
    padded_s[WIDTH-1:0] = hi_i;
    chunk_s             = padded_s[int'(ptr_r) * CHUNK +: CHUNK];
    valid_s             = '0;
    for (int j = 0; j < CHUNK; j++) begin
      valid_s[j] = ((int'(ptr_r) * CHUNK + j) < WIDTH);
    end
  end

  mprj_tie_chunk_chk #(
    .CHUNK (CHUNK)
  ) u_chunk_chk (
    .bits     (chunk_s),
    .valid    (valid_s),
    .zero_cnt (zero_cnt_s),
    .low_pos  (low_pos_s),
    .any_zero (any_zero_s)
  );

  // Scan control decodes and absolute index of the lowest zero in this chunk.
  always_comb begin
    last_chunk_s = (ptr_r == PTRW'(NCHUNK - 1));
    scanning_s   = (state_r == SCAN);
    idx_cand_s   = IDXW'(ptr_r) * IDXW'(CHUNK) + IDXW'(low_pos_s);
`ifdef MPRJ_TIE_MON_CONT_EN
    restart_s    = ((state_r == IDLE) && start_i) || (state_r == DONE);
`else
    restart_s    = (state_r == IDLE) && start_i;
`endif
  end

  // Next-state logic for the scan sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (last_chunk_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SCAN;
        end
      end
`ifdef MPRJ_TIE_MON_CONT_EN
      DONE:    state_nxt_s = SCAN;
`else
      DONE:    state_nxt_s = IDLE;
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, registered status outputs, accumulators and sticky alarm.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r     <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fault_o     <= 1'b0;
      fault_cnt_o <= '0;
      first_idx_o <= '0;
      ptr_r       <= '0;
    end else begin
      state_r <= state_nxt_s;
      busy_o  <= (state_nxt_s == SCAN);
      done_o  <= (state_nxt_s == DONE);

      if (restart_s) begin
        fault_cnt_o <= '0;
        first_idx_o <= '0;
        ptr_r       <= '0;
      end else if (scanning_s) begin
        fault_cnt_o <= fault_cnt_o + CNTW'(zero_cnt_s);
        if ((fault_cnt_o == CNTW'(0)) && any_zero_s) begin
          first_idx_o <= idx_cand_s;
        end
        if (!last_chunk_s) begin
          ptr_r <= ptr_r + PTRW'(1);
        end
      end

      // A detected zero takes priority over a same-cycle clear.
      if (scanning_s && any_zero_s) begin
        fault_o <= 1'b1;
      end else if (clr_i) begin
        fault_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mprj_tie_monitor.sv
// Scoreboard bench for mprj_tie_monitor: stimulus pushes the expected scan
// result, a monitor pops and compares on every done_o pulse.
module tb_mprj_tie_monitor;

  localparam int WIDTH = 463;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int IW    = $clog2(WIDTH);

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic [WIDTH-1:0] hi_i;
  logic             start_i;
  logic             clr_i;
  logic             busy_o;
  logic             done_o;
  logic             fault_o;
  logic [CW-1:0]    fault_cnt_o;
  logic [IW-1:0]    first_idx_o;

  typedef struct {
    int cnt;
    int idx;
    bit fault;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int busy_cnt  = 0;
  int done_seen = 0;

  mprj_tie_monitor dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .hi_i        (hi_i),
    .start_i     (start_i),
    .clr_i       (clr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fault_o     (fault_o),
    .fault_cnt_o (fault_cnt_o),
    .first_idx_o (first_idx_o)
  );

  // Free-running clock.
  always #5 wb_clk_i = ~wb_clk_i;

  // Cycle counter advanced at every active edge.
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: count busy cycles and score every completed scan.
  always @(negedge wb_clk_i) begin : mon
    exp_t e;
    if (wb_rst_i) begin
      busy_cnt = 0;
    end else begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_seen++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done_o=1 at cycle %0d, required no pending scan", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("busy_cycles", busy_cnt, 15);
          check("fault_cnt", fault_cnt_o, e.cnt);
          if (e.cnt != 0) check("first_idx", first_idx_o, e.idx);
          check("fault_at_done", fault_o, int'(e.fault));
        end
        busy_cnt = 0;
      end
    end
  end

  // One scan: optional clr_i pulse at scan cycle clr_k, optional start spam.
  task automatic run_scan(input logic [WIDTH-1:0] pat, input int ecnt, input int eidx,
                          input bit efault, input int clr_k, input bit spam);
    exp_t e;
    int   d0;
    bit   seen;
    @(negedge wb_clk_i);
    hi_i       = pat;
    start_i    = 1'b1;
    e.cnt      = ecnt;
    e.idx      = eidx;
    e.fault    = efault;
    e.done_cyc = cyc + 16;
    sb.push_back(e);
    d0   = done_seen;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge wb_clk_i);
      start_i = spam && (k >= 2) && (k <= 12);
      clr_i   = (k == clr_k);
      if (done_seen != d0) begin
        seen = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    clr_i   = 1'b0;
    check("done_arrived", seen, 1);
    repeat (3) @(negedge wb_clk_i);
  endtask

  task automatic clr_idle();
    @(negedge wb_clk_i);
    clr_i = 1'b1;
    @(negedge wb_clk_i);
    clr_i = 1'b0;
    check("fault_after_clr", fault_o, 0);
  endtask

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    logic [WIDTH-1:0] pat;
    int c;
    wb_rst_i = 1'b1;
    hi_i     = '1;
    start_i  = 1'b0;
    clr_i    = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_cnt", fault_cnt_o, 0);
    check("rst_idx", first_idx_o, 0);

`ifdef MPRJ_TIE_MON_CONT_EN
    // Continuous mode: one start, three passes, line 300 low only in pass 2.
    @(negedge wb_clk_i);
    hi_i    = '1;
    start_i = 1'b1;
    c       = cyc;
    sb.push_back('{cnt: 0, idx: 0, fault: 1'b0, done_cyc: c + 16});
    sb.push_back('{cnt: 1, idx: 300, fault: 1'b1, done_cyc: c + 32});
    sb.push_back('{cnt: 0, idx: 0, fault: 1'b1, done_cyc: c + 48});
    @(negedge wb_clk_i);
    start_i = 1'b0;
    while (cyc < c + 16) @(negedge wb_clk_i);
    hi_i[300] = 1'b0;
    while (cyc < c + 32) @(negedge wb_clk_i);
    hi_i = '1;
    while (cyc < c + 52) @(negedge wb_clk_i);
    check("cont_all_passes", sb.size(), 0);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("cont_rst_busy", busy_o, 0);
`else
    // All lines high.
    run_scan('1, 0, 0, 1'b0, 0, 1'b0);

    // Lines 5, 200, 462 low.
    pat = '1; pat[5] = 1'b0; pat[200] = 1'b0; pat[462] = 1'b0;
    run_scan(pat, 3, 5, 1'b1, 0, 1'b0);

    // Clean scan afterwards: count resets, alarm stays sticky.
    run_scan('1, 0, 0, 1'b1, 0, 1'b0);
    check("fault_sticky_idle", fault_o, 1);
    clr_idle();

    // clr_i in the same cycle chunk 6 reports line 200: set wins.
    pat = '1; pat[200] = 1'b0;
    run_scan(pat, 1, 200, 1'b1, 7, 1'b0);
    clr_idle();

    // start_i hammered during SCAN: single scan, single done.
    pat = '1; pat[100] = 1'b0;
    run_scan(pat, 1, 100, 1'b1, 0, 1'b1);
    repeat (20) @(negedge wb_clk_i);

    // Reset at scan cycle 7 aborts everything.
    @(negedge wb_clk_i);
    pat = '1; pat[0] = 1'b0;
    hi_i    = pat;
    start_i = 1'b1;
    c       = cyc;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    while (cyc < c + 7) @(negedge wb_clk_i);
    check("pre_rst_busy", busy_o, 1);
    check("pre_rst_cnt", fault_cnt_o, 1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_fault", fault_o, 0);
    check("abort_cnt", fault_cnt_o, 0);
    check("abort_idx", first_idx_o, 0);
    repeat (20) @(negedge wb_clk_i);
    check("abort_stays_idle", busy_o, 0);

    // Only line 0 low: padding never counted.
    pat = '1; pat[0] = 1'b0;
    run_scan(pat, 1, 0, 1'b1, 0, 1'b0);

    // Whole final partial chunk low: exactly 15 real lines counted.
    pat = '1;
    for (int i = 448; i < WIDTH; i++) pat[i] = 1'b0;
    run_scan(pat, 15, 448, 1'b1, 0, 1'b0);
`endif

    repeat (5) @(negedge wb_clk_i);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
